// File: rtl/issue_queue_pkg.sv
// Shared issue-queue sizing and handshake helpers, so decode and issue agree on
// queue depth and pointer widths.
package issue_queue_pkg;

  localparam int IQ_DEPTH = 8;

  typedef logic [$clog2(IQ_DEPTH)-1:0] iq_ptr_t;
  typedef logic [$clog2(IQ_DEPTH):0]   iq_count_t;

  // Pair-atomic handshake decode: 01 moves one entry, 11 moves two, anything
  // else (including 10, or a request not backed by the allow bits) moves none.
  function automatic logic [1:0] pair_count(input logic [1:0] req,
                                            input logic       allow_one,
                                            input logic       allow_two);
    if (req == 2'b01 && allow_one) return 2'd1;
    if (req == 2'b11 && allow_two) return 2'd2;
    return 2'd0;
  endfunction

endpackage

// File: rtl/issue_queue_ptr_add.sv
// Wrapping pointer increment by 0/1/2; wraps for free because DEPTH is a power of two.
module issue_queue_ptr_add #(
  parameter int PW = 3
) (
  input  logic [PW-1:0] ptr,
  input  logic [1:0]    inc,
  output logic [PW-1:0] sum
);

  assign sum = ptr + PW'(inc);

endmodule

// File: rtl/issue_queue.sv
// In-order dual-wide issue queue: up to two enqueues and two in-order issues per
// cycle, with a redirect flush that empties the queue.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int W     = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [1:0]               in_valid,
  input  logic [W-1:0]             in_data0,
  input  logic [W-1:0]             in_data1,
  output logic                     in_ready,
  output logic [1:0]               out_valid,
  output logic [W-1:0]             out_data0,
  output logic [W-1:0]             out_data1,
  input  logic [1:0]               out_take,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [PW-1:0] head_p1, tail_p1, head_nxt, tail_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    nin, nout;
  logic          enq_ok;

  // Readiness looks only at registered occupancy, so slots freed this cycle do not count.
  assign in_ready  = (cnt <= CW'(DEPTH - 2));
  assign out_valid = flush ? 2'b00 : {cnt >= CW'(2), cnt >= CW'(1)};
  assign out_data0 = mem[head];
  assign out_data1 = mem[head_p1];
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));

  assign enq_ok = in_ready & ~flush;
  assign nin    = pair_count(in_valid, enq_ok, enq_ok);
  // A take of 11 with only one valid entry is dropped whole, not half-honoured.
  assign nout   = pair_count(out_take, out_valid[0], out_valid[1]);

  issue_queue_ptr_add #(.PW(PW)) u_head_p1  (.ptr(head), .inc(2'd1), .sum(head_p1));
  issue_queue_ptr_add #(.PW(PW)) u_tail_p1  (.ptr(tail), .inc(2'd1), .sum(tail_p1));
  issue_queue_ptr_add #(.PW(PW)) u_head_nxt (.ptr(head), .inc(nout), .sum(head_nxt));
  issue_queue_ptr_add #(.PW(PW)) u_tail_nxt (.ptr(tail), .inc(nin),  .sum(tail_nxt));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      cnt  <= cnt + CW'(nin) - CW'(nout);
    end
  end

  // Payload storage carries no reset; validity is tracked entirely by cnt.
  always_ff @(posedge clk) begin
    if (nin != 2'd0) mem[tail]    <= in_data0;
    if (nin == 2'd2) mem[tail_p1] <= in_data1;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (int'(cnt) + int'(nin) - int'(nout)) <= DEPTH);
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    (int'(cnt) + int'(nin) - int'(nout)) >= 0);

endmodule

// File: tb/tb_issue_queue.sv
// Randomised and directed bench for issue_queue: a driver feeds a queue-based
// reference model, and a monitor checks DUT outputs against it each cycle.
module tb_issue_queue;

  localparam int DEPTH = 8;
  localparam int W     = 128;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic [1:0]   in_valid = 2'b00;
  logic [W-1:0] in_data0 = '0;
  logic [W-1:0] in_data1 = '0;
  logic         in_ready;
  logic [1:0]   out_valid;
  logic [W-1:0] out_data0;
  logic [W-1:0] out_data1;
  logic [1:0]   out_take = 2'b00;
  logic [3:0]   count;
  logic         empty;
  logic         full;

  issue_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1), .in_ready(in_ready),
    .out_valid(out_valid), .out_data0(out_data0), .out_data1(out_data1), .out_take(out_take),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: program-order list of live payloads plus expected controls for this cycle.
  logic [W-1:0] exp_q[$];
  int           m_cnt = 0;
  int           e_cnt = 0;
  logic [1:0]   e_valid = 2'b00;
  logic         e_ready = 1'b1;
  logic         e_empty = 1'b1;
  logic         e_full  = 1'b0;
  int unsigned  seq = 1;
  logic         rnd_payload = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int unsigned s);
    logic [W-1:0] v;
    v = W'(s);
    if (rnd_payload) v[W-1:32] = {$urandom, $urandom, $urandom};
    return v;
  endfunction

  task automatic set_expect();
    e_cnt   = m_cnt;
    e_ready = (DEPTH - m_cnt) >= 2;
    e_empty = (m_cnt == 0);
    e_full  = (m_cnt == DEPTH);
    e_valid = flush ? 2'b00 : {m_cnt >= 2, m_cnt >= 1};
  endtask

  // One cycle of stimulus; the model advances by the rules of a pair-atomic FIFO.
  task automatic drive(input logic f, input logic [1:0] iv, input logic [1:0] tk);
    int acc_in, acc_out;
    @(posedge clk); #1;
    flush    = f;
    in_valid = iv;
    in_data0 = mk(seq);
    in_data1 = mk(seq + 1);
    out_take = tk;
    seq += 2;
    set_expect();
    if (f) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      acc_in  = (!e_ready) ? 0 : (iv == 2'b01) ? 1 : (iv == 2'b11) ? 2 : 0;
      acc_out = (tk == 2'b01 && m_cnt >= 1) ? 1 : (tk == 2'b11 && m_cnt >= 2) ? 2 : 0;
      if (acc_in >= 1) exp_q.push_back(in_data0);
      if (acc_in == 2) exp_q.push_back(in_data1);
      m_cnt = m_cnt + acc_in - acc_out;
    end
  endtask

  // Monitor: compares controls and pops the scoreboard for every entry the DUT issues.
  always @(negedge clk) begin
    int np;
    chk("count", W'(count), W'(e_cnt));
    chk("out_valid", W'(out_valid), W'(e_valid));
    chk("in_ready", W'(in_ready), W'(e_ready));
    chk("empty", W'(empty), W'(e_empty));
    chk("full", W'(full), W'(e_full));
    if (out_valid[0]) begin
      if (exp_q.size() < 1) begin
        checks++; errors++;
        $display("FAIL data0 got %0h want no-entry at %0t", out_data0, $time);
      end else chk("data0", out_data0, exp_q[0]);
    end
    if (out_valid[1]) begin
      if (exp_q.size() < 2) begin
        checks++; errors++;
        $display("FAIL data1 got %0h want no-entry at %0t", out_data1, $time);
      end else chk("data1", out_data1, exp_q[1]);
    end
    np = 0;
    if (out_take == 2'b01 && out_valid[0]) np = 1;
    else if (out_take == 2'b11 && out_valid == 2'b11) np = 2;
    repeat (np) if (exp_q.size() > 0) void'(exp_q.pop_front());
  end

  task automatic async_reset();
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async_count", W'(count), W'(0));
    chk("async_empty", W'(empty), W'(1));
    exp_q.delete();
    m_cnt    = 0;
    flush    = 1'b1;
    in_valid = 2'b11;
    out_take = 2'b11;
    set_expect();
    e_valid  = 2'b00;
    @(posedge clk); #1;
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 2'b00;
    out_take = 2'b00;
    set_expect();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Pair enqueue, then fill to full and check refusal and a double take.
    drive(0, 2'b11, 2'b00);
    drive(0, 2'b00, 2'b00);
    for (int i = 0; i < 3; i++) drive(0, 2'b11, 2'b00);
    drive(0, 2'b11, 2'b00);
    drive(0, 2'b01, 2'b00);
    drive(0, 2'b00, 2'b11);
    drive(0, 2'b00, 2'b00);

    // Steady push-2/take-2 walks both pointers across the wrap.
    for (int i = 0; i < 10; i++) drive(0, 2'b11, 2'b11);

    // Count 7: single enqueue refused while a single take drains one.
    drive(0, 2'b01, 2'b00);
    drive(0, 2'b01, 2'b01);
    drive(0, 2'b00, 2'b00);

    // Flush at count 5 with enqueue and take both requested.
    drive(0, 2'b00, 2'b01);
    drive(1, 2'b11, 2'b11);
    drive(0, 2'b00, 2'b00);

    // Count 1: take 11 dropped, in_valid 10 ignored, then async reset mid-cycle.
    drive(0, 2'b01, 2'b00);
    drive(0, 2'b00, 2'b11);
    drive(0, 2'b10, 2'b00);
    drive(0, 2'b11, 2'b00);
    drive(0, 2'b00, 2'b00);
    async_reset();
    drive(0, 2'b00, 2'b00);

    // Randomised traffic with occasional flushes.
    rnd_payload = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      logic f;
      logic [1:0] iv, tk;
      f  = ($urandom_range(0, 31) == 0);
      iv = 2'($urandom_range(0, 3));
      tk = 2'($urandom_range(0, 3));
      drive(f, iv, tk);
    end
    drive(0, 2'b00, 2'b00);
    async_reset();
    drive(0, 2'b00, 2'b00);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
